pll_lock_supervisor: RTL



---
 rtl/pll_lock_supervisor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock stability, holds
// the system reset request until the lock is stable, and retries or faults on failure.
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 3,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 pll_locked,
   input  logic                                 force_relock,
   input  logic                                 clear_fault,
   output logic                                 pll_rst,
   output logic                                 sys_rst_req,
   output logic                                 locked_ok,
   output logic                                 lock_lost,
   output logic                                 fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
   output logic [2:0]                           state_dbg
);

   localparam int RW   = $clog2(MAX_RETRIES + 1);
   localparam int MAX1 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAXC = (MAX1 > STABLE_CYCLES) ? MAX1 : STABLE_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] RST_END = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TMO_END = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_END = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [RW-1:0]          retry_n;
   logic                   lost_n;
   logic                   restart;
   logic                   timed;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lk;

   // pll_locked is asynchronous to clk; only the last stage is ever used.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], pll_locked};
   end
   assign lk = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_PLL_RST;
         cnt         <= '0;
         retry_count <= '0;
         lock_lost   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         retry_count <= retry_n;
         lock_lost   <= lost_n;
      end
   end

   always_comb begin
      state_n = state;
      retry_n = retry_count;
      lost_n  = lock_lost;
      restart = 1'b0;
      // A relock request overrides every lock/timeout event, but never leaves FAULT.
      if (force_relock && state != S_FAULT) begin
         state_n = S_PLL_RST;
         restart = 1'b1;
      end else begin
         case (state)
            S_PLL_RST: begin
               if (cnt == RST_END) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (lk) begin
                  state_n = S_STABLE;
               end else if (cnt == TMO_END) begin
                  if (retry_count == RTY_MAX) begin
                     state_n = S_FAULT;
                  end else begin
                     retry_n = retry_count + RW'(1);
                     state_n = S_PLL_RST;
                  end
               end
            end
            S_STABLE: begin
               if (!lk) begin
                  state_n = S_WAIT_LOCK;
               end else if (cnt == STB_END) begin
                  state_n = S_RUN;
                  retry_n = '0;
               end
            end
            S_RUN: begin
               if (!lk) begin
                  lost_n  = 1'b1;
                  state_n = S_PLL_RST;
               end
            end
            S_FAULT: begin
               if (clear_fault) begin
                  state_n = S_PLL_RST;
                  retry_n = '0;
                  lost_n  = 1'b0;
               end
            end
            default: state_n = S_PLL_RST;
         endcase
      end
      timed = (state == S_PLL_RST) || (state == S_WAIT_LOCK) || (state == S_STABLE);
      cnt_n = (restart || state_n != state || !timed) ? '0 : cnt + CW'(1);
   end

   assign pll_rst     = (state == S_PLL_RST) || (state == S_FAULT);
   assign sys_rst_req = (state != S_RUN);
   assign locked_ok   = (state == S_RUN);
   assign fault       = (state == S_FAULT);
   assign state_dbg   = state;

endmodule
